// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared state type and index-width helper for the SDRAM round-robin arbiter
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    // Width of a counter or index covering 0..n-1; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// rtl/sdram_arb_rr_pick.sv - combinational round-robin picker starting after rr_ptr
module sdram_arb_rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    localparam int IDX_W = idx_w(NUM_CLIENTS)
)(
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic [IDX_W-1:0]       winner,
    output logic                   valid
);

    // Scan clients rr_ptr+1, rr_ptr+2, ... with wrap; the first requester wins.
    always_comb begin
        int idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CLIENTS;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter_rr.sv
// rtl/sdram_arbiter_rr.sv - N-client SDRAM port arbiter with round-robin, real-time override and stall timeout
module sdram_arbiter_rr
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 22,
    parameter int DATA_W      = 128,
    parameter int MAX_BURST   = 8,
    parameter int TIMEOUT_CYC = 1024,
    parameter int RT_EN       = 1,
    localparam int BE_W  = DATA_W / 8,
    localparam int IDX_W = idx_w(NUM_CLIENTS),
    localparam int BC_W  = idx_w(MAX_BURST),
    localparam int TO_W  = idx_w(TIMEOUT_CYC)
)(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          arb_en,
    input  logic                          rt_window,
    input  logic [NUM_CLIENTS-1:0]        cl_rd,
    input  logic [NUM_CLIENTS-1:0]        cl_wr,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wrdata,
    input  logic [NUM_CLIENTS*BE_W-1:0]   cl_be,
    output logic [NUM_CLIENTS-1:0]        cl_wait,
    output logic [NUM_CLIENTS-1:0]        cl_ac,
    output logic [DATA_W-1:0]             cl_rddata,
    output logic [ADDR_W-1:0]             ar_addr,
    output logic [BE_W-1:0]               ar_be,
    output logic                          ar_read,
    output logic                          ar_write,
    output logic [DATA_W-1:0]             ar_wrdata,
    input  logic                          ar_ac,
    input  logic [DATA_W-1:0]             ar_rddata,
    output logic [IDX_W-1:0]              owner,
    output logic                          owner_valid,
    output logic                          timeout_pulse,
    output logic                          protocol_err
);

    arb_state_t             state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [BC_W-1:0]        burst_cnt;
    logic [TO_W-1:0]        to_cnt;
    logic                   err_hold;

    logic [NUM_CLIENTS-1:0] req;
    logic [IDX_W-1:0]       rr_winner;
    logic                   rr_valid;
    logic                   rt_win;
    logic                   preempt;
    logic                   own_rd;
    logic                   own_wr;
    logic                   own_req;
    logic                   burst_last;
    logic                   in_own;

    assign req        = cl_rd | cl_wr;
    assign in_own     = (state == ST_OWN);
    assign own_rd     = cl_rd[owner];
    assign own_wr     = cl_wr[owner];
    assign own_req    = own_rd | own_wr;
    assign rt_win     = (RT_EN != 0) && rt_window && req[0];
    assign preempt    = rt_win && (owner != '0);
    assign burst_last = (burst_cnt == BC_W'(MAX_BURST - 1));

    // Abort fires on the last tolerated stalled cycle; the forced idle follows in RELEASE.
    assign timeout_pulse = (TIMEOUT_CYC != 0) && in_own && own_req && !ar_ac &&
                           (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    // Report a rd+wr collision once per transaction, not on every held cycle.
    assign protocol_err  = in_own && own_rd && own_wr && !err_hold;
    assign cl_rddata     = ar_rddata;

    sdram_arb_rr_pick #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (rr_winner),
        .valid  (rr_valid)
    );

    // Route the owner's request slice to the controller and its acknowledge back.
    always_comb begin
        cl_wait   = '1;
        cl_ac     = '0;
        ar_addr   = '0;
        ar_wrdata = '0;
        ar_be     = '1;
        ar_read   = 1'b0;
        ar_write  = 1'b0;
        if (in_own) begin
            cl_wait[owner] = 1'b0;
            cl_ac[owner]   = ar_ac;
            ar_addr        = cl_addr[int'(owner)*ADDR_W +: ADDR_W];
            ar_wrdata      = cl_wrdata[int'(owner)*DATA_W +: DATA_W];
            ar_be          = cl_be[int'(owner)*BE_W +: BE_W];
            ar_read        = own_rd;
            ar_write       = own_wr & ~own_rd;
        end
    end

    // Grant, burst accounting, stall timeout and release sequencing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            owner       <= '0;
            owner_valid <= 1'b0;
            rr_ptr      <= IDX_W'(NUM_CLIENTS - 1);
            burst_cnt   <= '0;
            to_cnt      <= '0;
            err_hold    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_en && (rt_win || rr_valid)) begin
                        state       <= ST_OWN;
                        owner_valid <= 1'b1;
                        burst_cnt   <= '0;
                        to_cnt      <= '0;
                        err_hold    <= 1'b0;
                        if (rt_win) begin
                            owner <= '0;
                        end else begin
                            owner  <= rr_winner;
                            rr_ptr <= rr_winner;
                        end
                    end
                end
                ST_OWN: begin
                    if (protocol_err) begin
                        err_hold <= 1'b1;
                    end
                    if (ar_ac) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        to_cnt    <= '0;
                        err_hold  <= 1'b0;
                        if (burst_last || preempt || !arb_en) begin
                            state       <= ST_RELEASE;
                            owner_valid <= 1'b0;
                        end
                    end else if (!own_req || timeout_pulse) begin
                        state       <= ST_RELEASE;
                        owner_valid <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state       <= ST_IDLE;
                    owner_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter_rr.sv
// tb/tb_sdram_arbiter_rr.sv - self-checking bench for sdram_arbiter_rr against a behavioural model
module tb_sdram_arbiter_rr;

    localparam int N    = 4;
    localparam int AW   = 22;
    localparam int DW   = 128;
    localparam int BW   = DW / 8;
    localparam int MAXB = 8;
    localparam int TO   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n = 1'b0;
    logic              arb_en = 1'b0, rt_window = 1'b0, ar_ac = 1'b0;
    logic [N-1:0]      cl_rd = '0, cl_wr = '0;
    logic [N*AW-1:0]   cl_addr = '0;
    logic [N*DW-1:0]   cl_wrdata = '0;
    logic [N*BW-1:0]   cl_be = '0;
    logic [DW-1:0]     ar_rddata = '0;
    logic [N-1:0]      cl_wait, cl_ac;
    logic [DW-1:0]     cl_rddata, ar_wrdata;
    logic [AW-1:0]     ar_addr;
    logic [BW-1:0]     ar_be;
    logic              ar_read, ar_write, owner_valid, timeout_pulse, protocol_err;
    logic [1:0]        owner;

    sdram_arbiter_rr #(
        .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW),
        .MAX_BURST(MAXB), .TIMEOUT_CYC(TO), .RT_EN(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .arb_en(arb_en), .rt_window(rt_window),
        .cl_rd(cl_rd), .cl_wr(cl_wr), .cl_addr(cl_addr), .cl_wrdata(cl_wrdata), .cl_be(cl_be),
        .cl_wait(cl_wait), .cl_ac(cl_ac), .cl_rddata(cl_rddata),
        .ar_addr(ar_addr), .ar_be(ar_be), .ar_read(ar_read), .ar_write(ar_write),
        .ar_wrdata(ar_wrdata), .ar_ac(ar_ac), .ar_rddata(ar_rddata),
        .owner(owner), .owner_valid(owner_valid),
        .timeout_pulse(timeout_pulse), .protocol_err(protocol_err)
    );

    // stimulus applied on the next step
    logic          s_rst, s_en, s_rt, s_ac;
    logic [N-1:0]  s_rd, s_wr;
    logic [AW-1:0] s_addr [N];
    logic [DW-1:0] s_data [N];
    logic [BW-1:0] s_be   [N];
    logic [DW-1:0] s_rdd;

    // behavioural model: who holds the port, how many acks, how long stalled
    bit   m_valid, m_cool, m_err_done;
    int   m_owner, m_ptr, m_acks, m_stall;
    bit   cyc_valid;
    logic [N-1:0] last_ac;
    bit   last_to;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_cool = 0; m_err_done = 0;
        m_owner = 0; m_ptr = N - 1; m_acks = 0; m_stall = 0;
    endtask

    task automatic clear_stim();
        s_en = 1; s_rt = 0; s_ac = 0; s_rd = '0; s_wr = '0; s_rdd = '0;
        for (int i = 0; i < N; i++) begin
            s_addr[i] = '0; s_data[i] = '0; s_be[i] = '1;
        end
    endtask

    // One clock: apply inputs, compare every output with the model, then advance the model.
    task automatic step();
        logic [N-1:0]  e_wait, e_ac, req;
        logic          e_rd, e_wr, e_to, e_perr, o_rd, o_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [BW-1:0] e_be;
        int o, w;
        @(negedge clk);
        reset_n = s_rst; arb_en = s_en; rt_window = s_rt; ar_ac = s_ac; ar_rddata = s_rdd;
        cl_rd = s_rd; cl_wr = s_wr;
        for (int i = 0; i < N; i++) begin
            cl_addr[i*AW +: AW] = s_addr[i];
            cl_wrdata[i*DW +: DW] = s_data[i];
            cl_be[i*BW +: BW] = s_be[i];
        end
        #1;
        o = m_owner; req = s_rd | s_wr;
        o_rd = s_rd[o]; o_wr = s_wr[o];
        e_wait = '1; e_ac = '0; e_rd = 0; e_wr = 0; e_to = 0; e_perr = 0;
        e_addr = '0; e_wd = '0; e_be = '1;
        if (m_valid) begin
            e_wait[o] = 1'b0;
            e_ac[o]   = s_ac;
            e_rd      = o_rd;
            e_wr      = o_wr && !o_rd;
            e_addr    = s_addr[o]; e_wd = s_data[o]; e_be = s_be[o];
            e_to      = (o_rd || o_wr) && !s_ac && (m_stall == TO - 1);
            e_perr    = o_rd && o_wr && !m_err_done;
        end
        chk("owner_valid", owner_valid, m_valid);
        if (m_valid) chk("owner", owner, o);
        chk("cl_wait", cl_wait, e_wait);
        chk("cl_ac", cl_ac, e_ac);
        chk("ar_read", ar_read, e_rd);
        chk("ar_write", ar_write, e_wr);
        chk("ar_addr", ar_addr, e_addr);
        chk("ar_wrdata", ar_wrdata, e_wd);
        chk("ar_be", ar_be, e_be);
        chk("timeout_pulse", timeout_pulse, e_to);
        chk("protocol_err", protocol_err, e_perr);
        chk("cl_rddata", cl_rddata, s_rdd);
        cyc_valid = m_valid;
        last_ac = e_ac; last_to = e_to;
        if (!s_rst) begin
            model_reset();
        end else if (m_valid) begin
            if (e_perr) m_err_done = 1;
            if (s_ac) begin
                m_acks++; m_stall = 0; m_err_done = 0;
                if (m_acks == MAXB || (s_rt && req[0] && o != 0) || !s_en) begin
                    m_valid = 0; m_cool = 1;
                end
            end else if (!(o_rd || o_wr) || m_stall == TO - 1) begin
                m_valid = 0; m_cool = 1;
            end else begin
                m_stall++;
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else if (s_en && req != '0) begin
            w = -1;
            if (s_rt && req[0]) begin
                w = 0;
            end else begin
                for (int k = 1; k <= N; k++)
                    if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_ptr = w;
            end
            m_valid = 1; m_owner = w; m_acks = 0; m_stall = 0; m_err_done = 0;
        end
    endtask

    // Step until a new grant starts (owner_valid rising in the model).
    task automatic wait_grant(input string name);
        bit prev;
        prev = cyc_valid;
        for (int n = 0; n < 12; n++) begin
            step();
            if (!prev && cyc_valid) return;
            prev = cyc_valid;
        end
        checks++; errors++;
        $display("FAIL %s: no grant within 12 cycles", name);
    endtask

    // Clients keep a request until acked or aborted; controller acks issued commands at random.
    task automatic rand_stim();
        int t;
        for (int i = 0; i < N; i++) begin
            if (last_ac[i] || (last_to && m_owner == i)) begin
                s_rd[i] = 0; s_wr[i] = 0;
            end
            if (!(s_rd[i] || s_wr[i]) && $urandom_range(99) < (last_ac[i] ? 70 : 20)) begin
                t = $urandom_range(19);
                s_rd[i] = (t < 9) || (t == 19);
                s_wr[i] = (t >= 9);
                s_addr[i] = AW'($urandom);
                s_data[i] = {$urandom, $urandom, $urandom, $urandom};
                s_be[i] = BW'($urandom);
            end
        end
        if ($urandom_range(99) < 4) s_rt = ~s_rt;
        s_en = ($urandom_range(99) < 95);
        s_rdd = {$urandom, $urandom, $urandom, $urandom};
        if (m_valid && (s_rd[m_owner] || s_wr[m_owner])) s_ac = ($urandom_range(99) < 70);
        else s_ac = ($urandom_range(99) < 15);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, to_at;
        logic [N-1:0] acs;
        model_reset(); clear_stim(); s_rst = 0; cyc_valid = 0; last_ac = '0; last_to = 0;
        step(); step();
        chk("reset_owner_valid", owner_valid, 1'b0);
        chk("reset_cl_wait", cl_wait, 4'hF);
        chk("reset_ar_be", ar_be, 16'hFFFF);
        s_rst = 1;
        step();

        // 1: clients 1 and 3 together, rr_ptr=3 -> 1 then 3
        s_rd[1] = 1; s_addr[1] = 22'h00111; s_rd[3] = 1; s_addr[3] = 22'h00333;
        step();
        chk("s1_idle_wait", cl_wait, 4'hF);
        s_ac = 1; step();
        chk("s1_owner1", owner, 2'd1);
        chk("s1_wait1", cl_wait, 4'b1101);
        chk("s1_addr1", ar_addr, 22'h00111);
        chk("s1_ack1", cl_ac, 4'b0010);
        s_ac = 0; s_rd[1] = 0; step();
        step();
        chk("s1_release", owner_valid, 1'b0);
        wait_grant("s1_grant3");
        chk("s1_owner3", owner, 2'd3);
        chk("s1_addr3", ar_addr, 22'h00333);
        s_ac = 1; step(); s_ac = 0; s_rd[3] = 0; step(); step(); step();

        // 2: client 2 streams writes, acked every cycle -> exactly MAX_BURST acks
        s_wr[2] = 1; s_addr[2] = 22'h2A2A2; s_data[2] = {4{32'hC0FFEE02}}; s_ac = 1;
        wait_grant("s2_grant");
        cnt = 0;
        for (int n = 0; n < 20 && cyc_valid; n++) begin
            cnt += int'(cl_ac[2]);
            step();
        end
        chk("s2_burst_acks", 32'(cnt), 32'd8);
        chk("s2_release_wait", cl_wait, 4'hF);
        s_rd[1] = 1; s_addr[1] = 22'h01010;
        wait_grant("s2_grant1");
        chk("s2_other_first", owner, 2'd1);
        s_rd[1] = 0;
        wait_grant("s2_regrant");
        chk("s2_regrant2", owner, 2'd2);
        s_wr[2] = 0; s_ac = 0; step(); step(); step();

        // 3: real-time preemption after the outstanding ack; rr_ptr untouched
        s_rd[1] = 1; s_addr[1] = 22'h11111;
        wait_grant("s3_grant1");
        chk("s3_owner1", owner, 2'd1);
        s_ac = 1; step(); s_ac = 0; step();
        s_rt = 1; s_rd[0] = 1; s_addr[0] = 22'h00100; step();
        chk("s3_hold_until_ack", owner, 2'd1);
        s_ac = 1; step();
        chk("s3_last_ack", cl_ac, 4'b0010);
        s_ac = 0; step();
        chk("s3_release", owner_valid, 1'b0);
        s_rd[2] = 1; s_addr[2] = 22'h22222;
        wait_grant("s3_grant0");
        chk("s3_owner0", owner, 2'd0);
        chk("s3_addr0", ar_addr, 22'h00100);
        s_rt = 0; step();
        chk("s3_rt_fall_keeps", owner, 2'd0);
        chk("s3_rt_fall_valid", owner_valid, 1'b1);
        s_ac = 1; step(); s_ac = 0; s_rd[0] = 0;
        wait_grant("s3_grant_rr");
        chk("s3_rr_ptr_kept", owner, 2'd2);
        s_ac = 1; step(); s_ac = 0; s_rd = '0; step(); step(); step();

        // 4: stalled read times out on the 16th stalled cycle
        s_rd[3] = 1; s_addr[3] = 22'h3C3C3;
        wait_grant("s4_grant");
        to_at = 0; acs = '0;
        for (int k = 1; k <= 20 && cyc_valid; k++) begin
            if (timeout_pulse) to_at = k;
            acs |= cl_ac;
            step();
        end
        chk("s4_timeout_cycle", 32'(to_at), 32'd16);
        chk("s4_no_ack", acs, 4'h0);
        chk("s4_read_dropped", ar_read, 1'b0);
        chk("s4_owner_valid", owner_valid, 1'b0);
        s_rd[3] = 0; step(); step();

        // 5: rd and wr together -> read wins, one protocol_err pulse
        s_rd[2] = 1; s_wr[2] = 1; s_be[2] = 16'h00FF; s_addr[2] = 22'h05050;
        wait_grant("s5_grant");
        chk("s5_read", ar_read, 1'b1);
        chk("s5_write", ar_write, 1'b0);
        chk("s5_be", ar_be, 16'h00FF);
        cnt = int'(protocol_err);
        step(); cnt += int'(protocol_err);
        step(); cnt += int'(protocol_err);
        s_ac = 1; step(); cnt += int'(protocol_err);
        chk("s5_err_pulses", 32'(cnt), 32'd1);
        s_ac = 0; s_rd = '0; s_wr = '0; s_be[2] = '1; step(); step(); step();

        // 6: asynchronous reset mid-write, then rr restarts at client 0
        s_wr[1] = 1; s_addr[1] = 22'h16161; s_data[1] = {4{32'hDEAD0001}};
        wait_grant("s6_grant");
        chk("s6_writing", ar_write, 1'b1);
        #2 reset_n = 1'b0; s_rst = 0;
        #1;
        chk("s6_async_write", ar_write, 1'b0);
        chk("s6_async_wait", cl_wait, 4'hF);
        chk("s6_async_valid", owner_valid, 1'b0);
        model_reset();
        step(); step();
        clear_stim(); s_rst = 1;
        s_rd[0] = 1; s_rd[2] = 1;
        wait_grant("s6_regrant");
        chk("s6_first_client0", owner, 2'd0);
        s_ac = 1; step(); s_ac = 0; s_rd = '0; step(); step(); step();

        // randomized traffic against the model
        last_ac = '0; last_to = 0;
        for (int n = 0; n < 2500; n++) begin
            rand_stim();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
